// File: rtl/addr_wrap_counter_pkg.sv
// ---------------------------------------------------------------------------
// addr_wrap_counter_pkg
//   Shared definitions for the wrapping address counter and the pointer
//   blocks that reuse it.
//   Contents:
//     addr_width() - address width needed to hold 0..rollover-1
//     addr_params_ok() - parameter legality predicate, usable at elaboration
// ---------------------------------------------------------------------------
package addr_wrap_counter_pkg;

  // Width of an address that ranges over 0..rollover-1. A rollover of 1 or
  // less is illegal elsewhere, but the function still returns a usable
  // width of 1 so that elaboration reaches the legality checks instead of
  // failing on a zero-width vector first.
  function automatic int addr_width(input int rollover);
    if (rollover <= 2) begin
      return 1;
    end
    return $clog2(rollover);
  endfunction

  // True when the three counter parameters form a legal combination.
  function automatic bit addr_params_ok(input int rollover,
                                        input int rst_addr,
                                        input int incr_amt);
    return (rollover >= 2) &&
           (rst_addr >= 0) && (rst_addr < rollover) &&
           (incr_amt >= 1) && (incr_amt <= rollover);
  endfunction

endpackage : addr_wrap_counter_pkg

// File: rtl/addr_wrap_counter_if.sv
// ---------------------------------------------------------------------------
// addr_wrap_counter_if
//   Strobe/address bundle between a pointer user and addr_wrap_counter.
//   Parameter:
//     ROLLOVER - address modulus; sets the address width
//   Signals:
//     incr_in  - advance strobe, one step per rising edge it is sampled high
//     addr_out - current address, straight from the counter register
//   Strobe semantics: there is no ready. Every rising edge on which incr_in
//   is high (and reset is released) consumes exactly one step; the new
//   address appears on addr_out after that edge. Holding incr_in high for N
//   edges advances N steps.
//   Modports:
//     master - the pointer user: drives incr_in, observes addr_out
//     slave  - the counter:      observes incr_in, drives addr_out
// ---------------------------------------------------------------------------
interface addr_wrap_counter_if
  import addr_wrap_counter_pkg::*;
#(
  parameter int ROLLOVER = 64
) ();

  localparam int ADDR_W = addr_width(ROLLOVER);

  logic              incr_in;
  logic [ADDR_W-1:0] addr_out;

  modport master (
    output incr_in,
    input  addr_out
  );

  modport slave (
    input  incr_in,
    output addr_out
  );

endinterface : addr_wrap_counter_if

// File: rtl/addr_wrap_counter.sv
// ---------------------------------------------------------------------------
// addr_wrap_counter
//   Registered address generator for circular-buffer pointers. Holds an
//   address, advances it by INCR_AMT on each sampled strobe, and wraps
//   modulo ROLLOVER. Reset loads RST_ADDR.
//   Parameters:
//     ROLLOVER - modulus, legal addresses 0..ROLLOVER-1 (>= 2)
//     RST_ADDR - address loaded by reset (< ROLLOVER)
//     INCR_AMT - step per strobe (1..ROLLOVER)
//   Ports:
//     clk_in - single clock, rising edge
//     rst_in - synchronous active-low reset; wins over the strobe
//     bus    - slave side of addr_wrap_counter_if (incr_in in, addr_out out)
//   addr_out is driven straight from the register; nothing combinational
//   reaches it from the inputs.
// ---------------------------------------------------------------------------
module addr_wrap_counter
  import addr_wrap_counter_pkg::*;
#(
  parameter int ROLLOVER = 64,
  parameter int RST_ADDR = 0,
  parameter int INCR_AMT = 1
) (
  input  logic                clk_in,
  input  logic                rst_in,
  addr_wrap_counter_if.slave  bus
);

  localparam int ADDR_W = addr_width(ROLLOVER);
  // One spare bit so addr + step never overflows before the wrap compare.
  localparam int SUM_W  = ADDR_W + 1;

  localparam logic [ADDR_W-1:0] RST_VAL  = ADDR_W'(RST_ADDR);
  localparam logic [SUM_W-1:0]  INCR_EXT = SUM_W'(INCR_AMT);
  localparam logic [SUM_W-1:0]  ROLL_EXT = SUM_W'(ROLLOVER);

  // -------------------------------------------------------------------------
  // Elaboration-time legality checks
  // -------------------------------------------------------------------------
  if (ROLLOVER < 2) begin : g_bad_rollover
    $error("addr_wrap_counter: ROLLOVER=%0d must be >= 2", ROLLOVER);
  end
  if ((RST_ADDR < 0) || (RST_ADDR >= ROLLOVER)) begin : g_bad_rst_addr
    $error("addr_wrap_counter: RST_ADDR=%0d must be in 0..ROLLOVER-1", RST_ADDR);
  end
  if ((INCR_AMT < 1) || (INCR_AMT > ROLLOVER)) begin : g_bad_incr_amt
    $error("addr_wrap_counter: INCR_AMT=%0d must be in 1..ROLLOVER", INCR_AMT);
  end
  if (!addr_params_ok(ROLLOVER, RST_ADDR, INCR_AMT)) begin : g_bad_params
    $error("addr_wrap_counter: illegal parameter combination");
  end

  // -------------------------------------------------------------------------
  // Next-address datapath
  //   addr < ROLLOVER and INCR_AMT <= ROLLOVER, so sum < 2*ROLLOVER and a
  //   single conditional subtract is enough to bring it back into range.
  //   When INCR_AMT == ROLLOVER the subtract always fires and the address
  //   is left unchanged, which is the intended behaviour.
  // -------------------------------------------------------------------------
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [SUM_W-1:0]  sum;
  logic [SUM_W-1:0]  sum_wrapped;
  logic [SUM_W-1:0]  next_full;
  logic              wrap;

  always_comb begin
    sum         = {1'b0, addr_q} + INCR_EXT;
    sum_wrapped = sum - ROLL_EXT;
    wrap        = (sum >= ROLL_EXT);
    next_full   = wrap ? sum_wrapped : sum;
    addr_d      = next_full[ADDR_W-1:0];
  end

  // The wrapped result is always < ROLLOVER, so its top bit is zero by
  // construction; it is kept only for width symmetry.
  logic unused_next_msb;
  assign unused_next_msb = next_full[ADDR_W];

  // -------------------------------------------------------------------------
  // Address register: reset beats strobe, strobe beats hold.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      addr_q <= RST_VAL;
    end else if (bus.incr_in) begin
      addr_q <= addr_d;
    end
  end

  assign bus.addr_out = addr_q;

endmodule : addr_wrap_counter

// File: tb/tb_addr_wrap_counter.sv
// ---------------------------------------------------------------------------
// tb_addr_wrap_counter
//   Three counter instances exercised together:
//     A: ROLLOVER=64, RST_ADDR=24, INCR_AMT=4
//     B: ROLLOVER=11, RST_ADDR=0,  INCR_AMT=1
//     C: ROLLOVER=10, RST_ADDR=0,  INCR_AMT=4
//   Inputs change on the falling edge, outputs are sampled on the next
//   falling edge. The reference model is plain modulo arithmetic.
// ---------------------------------------------------------------------------
module tb_addr_wrap_counter;

  localparam int RA = 64, SA = 24, IA = 4;
  localparam int RB = 11, SB = 0,  IB = 1;
  localparam int RC = 10, SC = 0,  IC = 4;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;

  addr_wrap_counter_if #(.ROLLOVER(RA)) if_a ();
  addr_wrap_counter_if #(.ROLLOVER(RB)) if_b ();
  addr_wrap_counter_if #(.ROLLOVER(RC)) if_c ();

  addr_wrap_counter #(.ROLLOVER(RA), .RST_ADDR(SA), .INCR_AMT(IA)) dut_a (
    .clk_in (clk), .rst_in (rst_a), .bus (if_a.slave));
  addr_wrap_counter #(.ROLLOVER(RB), .RST_ADDR(SB), .INCR_AMT(IB)) dut_b (
    .clk_in (clk), .rst_in (rst_b), .bus (if_b.slave));
  addr_wrap_counter #(.ROLLOVER(RC), .RST_ADDR(SC), .INCR_AMT(IC)) dut_c (
    .clk_in (clk), .rst_in (rst_c), .bus (if_c.slave));

  // -------------------------------------------------------------------------
  // Scoreboard state
  // -------------------------------------------------------------------------
  int checks   = 0;
  int failures = 0;
  int ma, mb, mc;                 // model addresses
  logic [31:0] exp_q[$];          // expected A/B/C values for the current cycle

  function automatic int model_next(input int cur, input logic rst_n,
                                    input logic incr, input int rst_addr,
                                    input int step, input int roll);
    if (!rst_n) return rst_addr;
    if (incr)   return (cur + step) % roll;
    return cur;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int obs, input int lim);
    checks++;
    assert (obs < lim) else begin
      failures++;
      $error("FAIL %s observed=%0d expected<%0d", tag, obs, lim);
    end
  endtask

  // -------------------------------------------------------------------------
  // Driver: one clock of stimulus on all three instances, then compare.
  // -------------------------------------------------------------------------
  task automatic cycle(input logic ia, input logic ib, input logic ic,
                       input logic ra, input logic rb, input logic rc);
    if_a.incr_in = ia; if_b.incr_in = ib; if_c.incr_in = ic;
    rst_a = ra; rst_b = rb; rst_c = rc;
    ma = model_next(ma, ra, ia, SA, IA, RA);
    mb = model_next(mb, rb, ib, SB, IB, RB);
    mc = model_next(mc, rc, ic, SC, IC, RC);
    exp_q.push_back(32'(ma));
    exp_q.push_back(32'(mb));
    exp_q.push_back(32'(mc));
    @(posedge clk);
    @(negedge clk);
    chk("model_a", int'(if_a.addr_out), int'(exp_q.pop_front()));
    chk("model_b", int'(if_b.addr_out), int'(exp_q.pop_front()));
    chk("model_c", int'(if_c.addr_out), int'(exp_q.pop_front()));
    chk_range("range_a", int'(if_a.addr_out), RA);
    chk_range("range_b", int'(if_b.addr_out), RB);
    chk_range("range_c", int'(if_c.addr_out), RC);
  endtask

  // -------------------------------------------------------------------------
  // Directed then random sequence
  // -------------------------------------------------------------------------
  initial begin
    int hold_a, hold_b, hold_c;
    int exp_b;
    int c_seq[5];
    ma = 0; mb = 0; mc = 0;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    if_a.incr_in = 1'b0; if_b.incr_in = 1'b0; if_c.incr_in = 1'b0;
    @(negedge clk);

    // Reset with strobes high: reset must win.
    cycle(1, 1, 1, 0, 0, 0);
    chk("rst_a", int'(if_a.addr_out), 24);
    chk("rst_b", int'(if_b.addr_out), 0);
    chk("rst_c", int'(if_c.addr_out), 0);

    // A: three steps from 24.
    cycle(1, 0, 0, 1, 1, 1); chk("a_step1", int'(if_a.addr_out), 28);
    cycle(1, 0, 0, 1, 1, 1); chk("a_step2", int'(if_a.addr_out), 32);
    cycle(1, 0, 0, 1, 1, 1); chk("a_step3", int'(if_a.addr_out), 36);

    // A: reset mid-run while the strobe is high.
    cycle(0, 0, 0, 0, 1, 1); chk("a_rst2", int'(if_a.addr_out), 24);
    cycle(1, 0, 0, 1, 1, 1);
    cycle(1, 0, 0, 1, 1, 1); chk("a_at32", int'(if_a.addr_out), 32);
    cycle(1, 0, 0, 0, 1, 1); chk("a_midrst", int'(if_a.addr_out), 24);
    cycle(1, 0, 0, 1, 1, 1); chk("a_release", int'(if_a.addr_out), 28);

    // Hold on all instances for three cycles.
    hold_a = int'(if_a.addr_out);
    hold_b = int'(if_b.addr_out);
    hold_c = int'(if_c.addr_out);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 1, 1, 1);
      chk("hold_a", int'(if_a.addr_out), hold_a);
      chk("hold_b", int'(if_b.addr_out), hold_b);
      chk("hold_c", int'(if_c.addr_out), hold_c);
    end

    // A: 28 -> 60, then wrap to 0 and on to 4.
    for (int i = 0; i < 8; i++) cycle(1, 0, 0, 1, 1, 1);
    chk("a_at60", int'(if_a.addr_out), 60);
    cycle(1, 0, 0, 1, 1, 1); chk("a_wrap0", int'(if_a.addr_out), 0);
    cycle(1, 0, 0, 1, 1, 1); chk("a_wrap4", int'(if_a.addr_out), 4);

    // B: eleven steps from 0 wrap back to 0.
    for (int i = 1; i <= 11; i++) begin
      cycle(0, 1, 0, 1, 1, 1);
      exp_b = (i == 11) ? 0 : i;
      chk("b_seq", int'(if_b.addr_out), exp_b);
    end

    // C: stride 4 through modulus 10.
    c_seq = '{4, 8, 2, 6, 0};
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 1, 1, 1, 1);
      chk("c_seq", int'(if_c.addr_out), c_seq[i]);
    end

    // Random strobes with occasional resets on each instance.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)),
            1'($urandom_range(0, 15) != 0), 1'($urandom_range(0, 15) != 0),
            1'($urandom_range(0, 15) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_addr_wrap_counter
